minilogix2: RTL
===============

Name: minilogix2

Overview:
- Second-generation serially configured logic fabric: NLUT K-input LUT cells, each with a flop, feeding an NOUT-wide output crossbar.
- Configuration is shifted in over a slow, pin-driven 3-wire port (enable, strobe, data) that is synchronised into the clk domain. Load completeness is checked by a small state machine.
- Sits directly under the Tiny Tapeout top wrapper, replacing minilogix1.
- Adds over minilogix1: parametrised LUT count and fan-in, LUT feedback through flops, a load length check, and optional config readback.

Parameters:
- NIN, 8, number of fabric inputs.
- NOUT, 8, number of fabric outputs.
- NLUT, 8, number of LUT cells.
- K, 4, inputs per LUT.
- Derived (localparam): NSRC=NIN+NLUT+2; SELW=$clog2(NSRC); LB=2**K+K*SELW+1; CFG_BITS=NOUT*SELW+NLUT*LB (default 336).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_input  in  NIN  fabric inputs.
- o_output  out  NOUT  fabric outputs.
- i_load_en  in  1  load window, asynchronous pin.
- i_load_clk  in  1  bit strobe; data sampled on its rising edge; asynchronous pin.
- i_load_dat  in  1  serial config data, asynchronous pin.
- o_load_dat  out  1  readback data (see Optional Feature).
- dbg_state  out  3  current FSM state.

Behaviour:
- Single clock: clk. Reset is synchronous and active-high on rst.
- Synchronisers: each of i_load_en, i_load_clk and i_load_dat passes through a 2-FF synchroniser.
  - A third flop on the synced strobe gives rising-edge detection.
  - On an edge, the synced data bit is taken.
  - Strobe high and low times must each be at least 3 clk cycles.
- Config register cfg[CFG_BITS-1:0]: on each accepted bit, cfg <= {cfg[CFG_BITS-2:0], dat}. The first bit shifted ends at the MSB after a full load.
- Field map:
  - Output o select: cfg[o*SELW +: SELW].
  - LUT n base b = NOUT*SELW + n*LB.
  - Truth table: cfg[b +: 2**K], indexed by {in[K-1],...,in[0]}.
  - Input k select: cfg[b+2**K+k*SELW +: SELW].
  - Registered-output bit: cfg[b+LB-1].
- Source index encoding:
  - 0..NIN-1: i_input.
  - NIN..NIN+NLUT-1: LUT sources.
  - NIN+NLUT: constant 0.
  - NIN+NLUT+1: constant 1.
  - Any larger index: 0.
- LUT input muxes see LUT sources as the flop values q[n] only, so no combinational loops are possible.
- The output mux sees LUT n as q[n] if its reg bit is 1, otherwise the combinational value f[n].
- q[n] <= f[n] every clk while in RUN; q is held at 0 in every other state.
- FSM states (dbg_state encoding):
  - EMPTY=000: after reset.
  - LOAD=001.
  - RUN=010.
  - ERROR=011.
- FSM transitions:
  - EMPTY/RUN/ERROR -> LOAD on synced load_en = 1. Bit counter cleared to 0; q cleared.
  - In LOAD: each accepted bit shifts cfg and increments the counter, which saturates at CFG_BITS+1.
  - LOAD -> RUN on synced load_en falling, if counter == CFG_BITS.
  - LOAD -> ERROR on synced load_en falling otherwise (short or long load).
- o_output: combinational mux result when in RUN; 0 in all other states.
- RUN latency:
  - Reg-bit-0 paths from i_input to o_output are combinational (0 cycles).
  - Paths through q take 1 clk per flop.
- rst at any time, including mid-load:
  - cfg, counter, q and synchroniser flops go to 0; state goes to EMPTY.
  - o_output = 0, o_load_dat = 0, dbg_state = 000.
- A strobe edge in the same cycle as load_en falling is ignored.
- Edges outside LOAD are ignored and do not alter cfg.

Optional Feature:
- Macro: MINILOGIX_READBACK_EN.
- Defined:
  - o_load_dat is a flop loaded with cfg[CFG_BITS-1] on each accepted bit, before the shift.
  - A full load therefore streams out the previous configuration, MSB first, one bit per strobe.
  - o_load_dat is 0 after reset.
- Undefined: o_load_dat is tied to 0 and no readback flop exists.

Test Plan:
- Reset: assert rst 2 cycles, any inputs -> o_output=0x00, dbg_state=000, o_load_dat=0.
- AND gate load: 336 bits with LUT0 table 16'h8888, sel0=0, sel1=1, sel2=sel3=16, reg=0; out0 sel=8; all other selects 16.
  - After load: dbg_state=010.
  - i_input=0x03 -> o_output=0x01 in the same cycle.
  - i_input=0x01 -> o_output=0x00.
- Toggle flop: LUT1 table 16'h5555, sel0=9, reg=1; out1 sel=9.
  - In RUN, o_output[1] toggles every clk: 0,1,0,1...
  - Re-entering LOAD forces it to 0.
- Short/long load: 335 bits, then load_en low -> dbg_state=011, o_output=0x00. Repeat with 337 bits -> 011.
- Mid-load reset: rst after 100 bits -> dbg_state=000. A following full 336-bit load reaches RUN with the correct function; no residue from the aborted load.
- Readback (macro defined): load pattern A, then load pattern B -> o_load_dat sequence equals A MSB-first, bit-exact over 336 strobes.

Source files
------------

// File: rtl/minilogix2.sv
// minilogix2: serially configured fabric of K-input LUT cells with flops and an output crossbar.
// Defining MINILOGIX_READBACK_EN streams the previous configuration out on o_load_dat during a load.
module minilogix2 #(
    parameter int NIN  = 8,
    parameter int NOUT = 8,
    parameter int NLUT = 8,
    parameter int K    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIN-1:0]  i_input,
    output logic [NOUT-1:0] o_output,
    input  logic            i_load_en,
    input  logic            i_load_clk,
    input  logic            i_load_dat,
    output logic            o_load_dat,
    output logic [2:0]      dbg_state
);
    localparam int NSRC     = NIN + NLUT + 2;
    localparam int SELW     = $clog2(NSRC);
    localparam int TT       = 2**K;
    localparam int LB       = TT + K*SELW + 1;
    localparam int CFG_BITS = NOUT*SELW + NLUT*LB;
    localparam int CNTW     = $clog2(CFG_BITS + 2);

    typedef enum logic [2:0] {
        ST_EMPTY = 3'b000,
        ST_LOAD  = 3'b001,
        ST_RUN   = 3'b010,
        ST_ERROR = 3'b011
    } state_t;

    state_t              state_r, next_s;
    logic                en_meta_r, en_sync_r, en_prev_r;
    logic                stb_meta_r, stb_sync_r, stb_prev_r;
    logic                dat_meta_r, dat_sync_r;
    logic [CFG_BITS-1:0] cfg_r;
    logic [CNTW-1:0]     cnt_r;
    logic [NLUT-1:0]     q_r, f_s, lut_reg_s, lut_out_s;
    logic [NSRC-1:0]     lut_src_s, out_src_s;
    logic [NOUT-1:0]     mux_s;
    logic                stb_rise_s, en_fall_s, accept_s, enter_load_s, run_s;

    // Out-of-range selects read as 0.
    function automatic logic pick(input logic [NSRC-1:0] v, input logic [SELW-1:0] sel);
        logic r;
        if (int'(sel) < NSRC) r = v[sel];
        else r = 1'b0;
        return r;
    endfunction

    // Two-flop synchronisers on the load pins, plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            en_meta_r  <= 1'b0;
            en_sync_r  <= 1'b0;
            en_prev_r  <= 1'b0;
            stb_meta_r <= 1'b0;
            stb_sync_r <= 1'b0;
            stb_prev_r <= 1'b0;
            dat_meta_r <= 1'b0;
            dat_sync_r <= 1'b0;
        end else begin
            en_meta_r  <= i_load_en;
            en_sync_r  <= en_meta_r;
            en_prev_r  <= en_sync_r;
            stb_meta_r <= i_load_clk;
            stb_sync_r <= stb_meta_r;
            stb_prev_r <= stb_sync_r;
            dat_meta_r <= i_load_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    assign stb_rise_s = stb_sync_r & ~stb_prev_r;
    assign en_fall_s  = ~en_sync_r & en_prev_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_EMPTY;
        else     state_r <= next_s;
    end

    // FSM next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_EMPTY, ST_RUN, ST_ERROR: begin
                if (en_sync_r) next_s = ST_LOAD;
                else           next_s = state_r;
            end
            ST_LOAD: begin
                if (en_fall_s) next_s = (cnt_r == CNTW'(CFG_BITS)) ? ST_RUN : ST_ERROR;
                else           next_s = ST_LOAD;
            end
            default: next_s = ST_EMPTY;
        endcase
    end

    // FSM outputs: load control strobes and the gated fabric output
    always_comb begin
        enter_load_s = (state_r != ST_LOAD) && (next_s == ST_LOAD);
        accept_s     = (state_r == ST_LOAD) && stb_rise_s && !en_fall_s;
        run_s        = (state_r == ST_RUN) && (next_s == ST_RUN);
        if (state_r == ST_RUN) o_output = mux_s;
        else                   o_output = {NOUT{1'b0}};
    end

    assign dbg_state = state_r;

    // Config shift register and saturating bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_r <= {CFG_BITS{1'b0}};
            cnt_r <= {CNTW{1'b0}};
        end else if (enter_load_s) begin
            cnt_r <= {CNTW{1'b0}};
        end else if (accept_s) begin
            cfg_r <= {cfg_r[CFG_BITS-2:0], dat_sync_r};
            if (cnt_r != CNTW'(CFG_BITS + 1)) cnt_r <= cnt_r + CNTW'(1);
        end
    end

    // LUT flops follow f only while running; any other state parks them at zero
    always_ff @(posedge clk) begin
        if (rst)        q_r <= {NLUT{1'b0}};
        else if (run_s) q_r <= f_s;
        else            q_r <= {NLUT{1'b0}};
    end

    // LUT inputs only see flop values, so the fabric can never form a combinational loop.
    assign lut_src_s = {1'b1, 1'b0, q_r, i_input};

    for (genvar n = 0; n < NLUT; n++) begin : g_lut
        localparam int BASE = NOUT*SELW + n*LB;
        logic [K-1:0]  addr_s;
        logic [TT-1:0] tt_s;
        for (genvar k = 0; k < K; k++) begin : g_in
            assign addr_s[k] = pick(lut_src_s, cfg_r[BASE+TT+k*SELW +: SELW]);
        end
        assign tt_s         = cfg_r[BASE +: TT];
        assign f_s[n]       = tt_s[addr_s];
        assign lut_reg_s[n] = cfg_r[BASE+LB-1];
    end

    assign lut_out_s = (lut_reg_s & q_r) | (~lut_reg_s & f_s);
    assign out_src_s = {1'b1, 1'b0, lut_out_s, i_input};

    for (genvar o = 0; o < NOUT; o++) begin : g_out
        assign mux_s[o] = pick(out_src_s, cfg_r[o*SELW +: SELW]);
    end

`ifdef MINILOGIX_READBACK_EN
    logic rb_r;

    // Readback flop captures the outgoing MSB before each shift
    always_ff @(posedge clk) begin
        if (rst)           rb_r <= 1'b0;
        else if (accept_s) rb_r <= cfg_r[CFG_BITS-1];
        else               rb_r <= rb_r;
    end

    assign o_load_dat = rb_r;
`else
    assign o_load_dat = 1'b0;
`endif

endmodule
